// File: rtl/a000010_par_scheduler.sv
// -----------------------------------------------------------------------------
// a000010_par_scheduler
//
// Computes Euler's totient phi(n) by splitting one request across NWORKERS
// naive partial-sum workers. Worker k counts the i in {k+1, k+1+NWORKERS, ...}
// with i <= n that are coprime to n. This block latches n and starts every
// worker in the same cycle. It waits until all workers report ready, then adds
// their partial counts one per cycle into the final result.
//
// Optional feature (macro A000010_SCHED_CYCLES_EN):
//   When defined, a saturating 32-bit busy-cycle counter is built. Its value is
//   copied to 'cycles' when a result is written. When undefined, 'cycles' is
//   tied to zero.
//
// Ports:
//   clk              system clock; all state updates on the rising edge
//   reset_n          asynchronous active-low reset
//   start            request strobe; aborts and restarts from any state
//   n                argument, latched while start is high
//   result           phi(n) of the last completed request
//   result_ready     high when idle and start is low
//   worker_start     per-worker start pulse (all bits together)
//   worker_n         latched n, shared by all workers
//   worker_offset    slice k carries the constant k
//   worker_increment constant NWORKERS (common stride)
//   worker_result    slice k is worker k's partial count
//   worker_ready     bit k is worker k's ready flag
//   cycles           busy-cycle count of the last completed request
// -----------------------------------------------------------------------------
module a000010_par_scheduler #(
    parameter int WIDTH    = 18,
    parameter int NWORKERS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [WIDTH-1:0]          n,
    output logic [WIDTH-1:0]          result,
    output logic                      result_ready,
    output logic [NWORKERS-1:0]       worker_start,
    output logic [WIDTH-1:0]          worker_n,
    output logic [NWORKERS*WIDTH-1:0] worker_offset,
    output logic [WIDTH-1:0]          worker_increment,
    input  logic [NWORKERS*WIDTH-1:0] worker_result,
    input  logic [NWORKERS-1:0]       worker_ready,
    output logic [31:0]               cycles
);

    localparam int IDXW = (NWORKERS > 1) ? $clog2(NWORKERS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORKERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        REDUCE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  n_latched;
    logic [WIDTH-1:0]  acc;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  partial;
    logic [WIDTH-1:0]  sum;

    assign partial = worker_result[idx*WIDTH +: WIDTH];
    assign sum     = acc + partial;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start strobe wins over everything, so holding start
    // high keeps the block parked at LAUNCH entry.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = LAUNCH;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                LAUNCH:  state_next = SETTLE;
                // Workers still show the previous ready in the cycle they see
                // start, so ready is not trusted until one cycle later.
                SETTLE:  state_next = WAIT;
                WAIT:    state_next = (&worker_ready) ? REDUCE : WAIT;
                REDUCE:  state_next = (idx == LAST_IDX) ? IDLE : REDUCE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic. worker_start is gated by ~start so that a held start
    // produces a single pulse on the first cycle after start falls.
    always_comb begin
        worker_start = '0;
        result_ready = 1'b0;
        if (state == LAUNCH && !start) begin
            worker_start = '1;
        end
        if (state == IDLE && !start) begin
            result_ready = 1'b1;
        end
    end

    // Datapath: latch n, accumulate the partial counts one worker per cycle,
    // and publish the sum only after the last worker has been added.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_latched <= '0;
            acc       <= '0;
            idx       <= '0;
            result    <= '0;
        end else if (start) begin
            n_latched <= n;
            acc       <= '0;
            idx       <= '0;
        end else if (state == REDUCE) begin
            acc <= sum;
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                result <= sum;
            end
        end
    end

    assign worker_n         = n_latched;
    assign worker_increment = WIDTH'(NWORKERS);

    for (genvar k = 0; k < NWORKERS; k++) begin : g_offset
        assign worker_offset[k*WIDTH +: WIDTH] = WIDTH'(k);
    end

`ifdef A000010_SCHED_CYCLES_EN
    logic [31:0] busy_count;
    logic [31:0] busy_next;
    logic [31:0] cycles_q;

    assign busy_next = (&busy_count) ? busy_count : busy_count + 32'd1;

    // Busy-cycle counter. The final REDUCE cycle is included in the copied
    // value, so the count covers every non-idle cycle of the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_count <= '0;
            cycles_q   <= '0;
        end else if (start) begin
            busy_count <= '0;
        end else if (state != IDLE) begin
            busy_count <= busy_next;
            if (state == REDUCE && idx == LAST_IDX) begin
                cycles_q <= busy_next;
            end
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_a000010_par_scheduler.sv
// -----------------------------------------------------------------------------
// tb_a000010_par_scheduler
//
// Directed bench for a000010_par_scheduler with NWORKERS=4, WIDTH=18. Two
// worker models live in the bench:
//   naive mode : worker k tests i = k+1, k+5, ... <= n, one per cycle, and
//                counts the i with gcd(i, n) == 1
//   delay mode : worker k raises ready a fixed number of cycles after WAIT
//                begins and reports a fixed partial count
// A hold mask can force individual ready bits low.
// -----------------------------------------------------------------------------
module tb_a000010_par_scheduler;

    localparam int WIDTH    = 18;
    localparam int NWORKERS = 4;

    logic                      clk;
    logic                      reset_n;
    logic                      start;
    logic [WIDTH-1:0]          n;
    logic [WIDTH-1:0]          result;
    logic                      result_ready;
    logic [NWORKERS-1:0]       worker_start;
    logic [WIDTH-1:0]          worker_n;
    logic [NWORKERS*WIDTH-1:0] worker_offset;
    logic [WIDTH-1:0]          worker_increment;
    logic [NWORKERS*WIDTH-1:0] worker_result;
    logic [NWORKERS-1:0]       worker_ready;
    logic [31:0]               cycles;

    int checks;
    int errors;

    bit                  delay_mode;
    logic [NWORKERS-1:0] hold_mask;
    logic [NWORKERS-1:0] wready;
    logic [WIDTH-1:0]    wres [NWORKERS];
    int                  wcur [NWORKERS];
    int                  wcnt [NWORKERS];
    bit                  wbusy[NWORKERS];
    int                  dly  [NWORKERS];
    int                  part [NWORKERS];

    int pulses;
    int done_cyc;
    int ready_cyc;
    bit saw40;
    bit found;

    a000010_par_scheduler #(
        .WIDTH   (WIDTH),
        .NWORKERS(NWORKERS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .n               (n),
        .result          (result),
        .result_ready    (result_ready),
        .worker_start    (worker_start),
        .worker_n        (worker_n),
        .worker_offset   (worker_offset),
        .worker_increment(worker_increment),
        .worker_result   (worker_result),
        .worker_ready    (worker_ready),
        .cycles          (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign worker_ready  = wready & ~hold_mask;
    assign worker_result = {wres[3], wres[2], wres[1], wres[0]};

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Worker models. In delay mode, ready for worker k first shows in the
    // cycle dly[k] cycles after WAIT starts.
    initial begin
        wready = '1;
        for (int k = 0; k < NWORKERS; k++) begin
            wres[k]  = '0;
            wcur[k]  = 0;
            wcnt[k]  = 0;
            wbusy[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NWORKERS; k++) begin
            if (worker_start[k]) begin
                wready[k] <= 1'b0;
                if (delay_mode) begin
                    wcnt[k] <= dly[k] + 1;
                    wres[k] <= WIDTH'(part[k]);
                end else begin
                    wcur[k]  <= k + 1;
                    wres[k]  <= '0;
                    wbusy[k] <= 1'b1;
                end
            end else if (delay_mode) begin
                if (wcnt[k] > 0) begin
                    wcnt[k] <= wcnt[k] - 1;
                    if (wcnt[k] == 1) wready[k] <= 1'b1;
                end
            end else if (wbusy[k]) begin
                if (wcur[k] > int'(worker_n)) begin
                    wready[k] <= 1'b1;
                    wbusy[k]  <= 1'b0;
                end else begin
                    if (gcd(wcur[k], int'(worker_n)) == 1) wres[k] <= wres[k] + 1'b1;
                    wcur[k] <= wcur[k] + NWORKERS;
                end
            end
        end
    end

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Raise start with argument v for one cycle. result_ready must drop
    // combinationally in that same cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] v);
        @(negedge clk);
        start = 1'b1;
        n     = v;
        #1;
        checkOutput("result_ready_low_on_start", 32'(result_ready), 32'd0);
    endtask

    // Drop start and watch the block for up to 'budget' cycles. Cycle 1 is
    // LAUNCH. It records the first cycle with result_ready high, the first
    // cycle from WAIT onward with all ready bits high, and the start pulses.
    task automatic waitDone(input int budget);
        done_cyc  = -1;
        ready_cyc = -1;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int i = 1; i <= budget; i++) begin
            if (worker_start == 4'hF) pulses++;
            else if (worker_start != 4'h0) pulses += 100;
            if (ready_cyc < 0 && i >= 3 && worker_ready == 4'hF) ready_cyc = i;
            if (result == 18'd40) saw40 = 1'b1;
            if (result_ready) begin
                done_cyc = i;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        start      = 1'b0;
        n          = '0;
        reset_n    = 1'b0;
        delay_mode = 1'b0;
        hold_mask  = '0;
        saw40      = 1'b0;
        pulses     = 0;
        found      = 1'b0;
        dly[0] = 3;  dly[1] = 10; dly[2] = 5;  dly[3] = 7;
        part[0] = 2; part[1] = 3; part[2] = 4; part[3] = 5;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_result_ready", 32'(result_ready), 32'd1);
        checkOutput("reset_worker_start", 32'(worker_start), 32'd0);
        checkOutput("reset_worker_n", 32'(worker_n), 32'd0);
        checkOutput("reset_cycles", cycles, 32'd0);
        checkOutput("worker_increment", 32'(worker_increment), 32'd4);
        checkOutput("worker_offset_1", 32'(worker_offset[WIDTH +: WIDTH]), 32'd1);
        checkOutput("worker_offset_3", 32'(worker_offset[3*WIDTH +: WIDTH]), 32'd3);
        @(negedge clk);
        reset_n = 1'b1;

        // n=12 -> phi=4; exactly one start pulse.
        pulses = 0;
        applyStimulus(18'd12);
        waitDone(80);
        checkOutput("n12_done", 32'(done_cyc > 0), 32'd1);
        checkOutput("n12_result", 32'(result), 32'd4);
        checkOutput("n12_pulses", 32'(pulses), 32'd1);
        checkOutput("n12_worker_n", 32'(worker_n), 32'd12);

        // n=97 -> 96.
        applyStimulus(18'd97);
        waitDone(100);
        checkOutput("n97_result", 32'(result), 32'd96);

        // n=1 -> 1.
        applyStimulus(18'd1);
        waitDone(40);
        checkOutput("n1_result", 32'(result), 32'd1);

        // n=0 -> 0, with workers ready at once: minimum latency NWORKERS+4.
        applyStimulus(18'd0);
        waitDone(40);
        checkOutput("n0_result", 32'(result), 32'd0);
        checkOutput("n0_latency", 32'(done_cyc), 32'd8);

        // Delay-mode workers: sum 2+3+4+5 = 14, ready NWORKERS+1 after last.
        delay_mode = 1'b1;
        applyStimulus(18'd50);
        waitDone(60);
        checkOutput("delay_result", 32'(result), 32'd14);
        checkOutput("delay_last_ready", 32'(ready_cyc), 32'd13);
        checkOutput("delay_ready_gap", 32'(done_cyc - ready_cyc), 32'd5);
`ifdef A000010_SCHED_CYCLES_EN
        checkOutput("delay_cycles", cycles, 32'd17);
`else
        checkOutput("delay_cycles", cycles, 32'd0);
`endif

        // Restart: n=100 abandoned after twenty cycles, n=7 -> 6.
        delay_mode = 1'b0;
        pulses     = 0;
        saw40      = 1'b0;
        applyStimulus(18'd100);
        waitDone(19);
        checkOutput("restart_not_done", 32'(done_cyc), 32'hFFFF_FFFF);
        applyStimulus(18'd7);
        waitDone(60);
        checkOutput("restart_result", 32'(result), 32'd6);
        checkOutput("restart_no_40", 32'(saw40), 32'd0);
        checkOutput("restart_pulses", 32'(pulses), 32'd2);

        // Stuck worker 2 holds the block in WAIT; the old result is held.
        hold_mask = 4'b0100;
        applyStimulus(18'd12);
        waitDone(60);
        checkOutput("stuck_not_done", 32'(done_cyc), 32'hFFFF_FFFF);
        checkOutput("stuck_result_held", 32'(result), 32'd6);
        checkOutput("stuck_ready_low", 32'(result_ready), 32'd0);
        hold_mask = 4'b0000;
        waitDone(20);
        checkOutput("release_result", 32'(result), 32'd4);

        // Reset during REDUCE wipes the result immediately.
        delay_mode = 1'b1;
        applyStimulus(18'd33);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (worker_ready == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reduce_reached", 32'(found), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_result_ready", 32'(result_ready), 32'd1);
        checkOutput("midreset_worker_start", 32'(worker_start), 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        delay_mode = 1'b0;
        applyStimulus(18'd10);
        waitDone(60);
        checkOutput("after_reset_n10", 32'(result), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
